// File: rtl/transmitter_uart.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames run back-to-back
// while the FIFO has data, and tx always comes straight from a flop.
module transmitter_uart #(
  parameter int CLKS_PER_BIT = 5200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       tx,
  output logic       full,
  output logic [2:0] level,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       led
);
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  DEPTH_L = 3'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          push, pop, bit_end;

  // Full is judged on the pre-edge level, so a write while full is dropped
  // even when the transmitter pops on the same edge.
  assign full    = (level == DEPTH_L);
  assign push    = wr && !full;
  assign bit_end = (cnt == CNT_MAX);
  assign pop     = (level != 3'd0) && ((state == IDLE) || (state == STOP && bit_end));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level    <= level + {2'b00, push} - {2'b00, pop};
      overflow <= wr && full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
      led     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (pop) begin
            shreg <= mem[rptr];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt  <= '0;
            done <= 1'b1;
            led  <= ~led;
            // Chain straight into the next start bit when more data waits.
            if (pop) begin
              shreg <= mem[rptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_transmitter_uart.sv
// Bench for transmitter_uart: a frame-level model predicts FIFO status,
// a serial-line monitor decodes frames and checks them against a scoreboard.
module tb_transmitter_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, full, busy, done, overflow, led;
  logic [2:0] level;

  transmitter_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .wr(wr), .tx(tx), .full(full),
    .level(level), .busy(busy), .done(done), .overflow(overflow), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  byte unsigned exp_q[$];
  byte unsigned mq[$];
  int rem = 0;
  int frames_since_rst = 0, frames_total = 0, done_seen = 0;
  int cyc = 0, last_edge = 0;
  int start_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: FIFO as a queue, transmitter as "clocks left in current frame".
  task automatic step(input logic w, input logic [7:0] d);
    bit full_m, pop_m, ovf_m;
    wr = w;
    data = d;
    full_m = (mq.size() == DEPTH);
    pop_m  = (mq.size() > 0) && (rem <= 1);
    ovf_m  = w && full_m;
    if (rem == 1) begin
      frames_since_rst++;
      frames_total++;
    end
    if (pop_m) begin
      void'(mq.pop_front());
      rem = FRAME;
    end else if (rem > 0) begin
      rem--;
    end
    if (w && !full_m) begin
      mq.push_back(d);
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    last_edge = cyc;
    chk("level", level, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", overflow, ovf_m);
    chk("busy", busy, rem > 0);
    chk("led", led, frames_since_rst % 2);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rem > 0 || mq.size() > 0) && n < 2000) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("idle_timeout", n < 2000, 1);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  // Serial monitor: start seen at negedge 0, bit i sampled at 4(i+1)+1.
  int mcnt = 0;
  bit mact = 0, exp_done = 0;
  logic [7:0] sh;
  always @(negedge clk) begin
    if (!rst_n) begin
      mact = 0;
      exp_done = 0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", done, 1);
        exp_done = 0;
      end else if (done === 1'b1) begin
        chk("done_spurious", done, 0);
      end
      if (done === 1'b1) done_seen++;
      if (!mact) begin
        if (tx === 1'b0) begin
          mact = 1;
          mcnt = 0;
          start_t.push_back(cyc);
        end
      end else begin
        mcnt++;
        if (mcnt == 1) chk("start_bit", tx, 0);
        else if (mcnt >= 5 && mcnt <= 33 && (mcnt - 1) % CPB == 0) sh[3'((mcnt - 5) / CPB)] = tx;
        else if (mcnt == 37) begin
          chk("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected none", sh);
          end else begin
            chk("byte", sh, exp_q.pop_front());
          end
        end else if (mcnt == FRAME - 1) begin
          mact = 0;
          exp_done = 1;
        end
      end
    end
  end

  initial begin
    int n;
    int wcyc;
    logic led_before;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_led", led, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    step(1'b0, 8'h00);

    // Single byte from idle
    step(1'b1, 8'hA5);
    wcyc = last_edge;
    wait_idle();
    chk("latency", start_t[0] - wcyc, 1);
    chk("led_a5", led, 1);

    // Back-to-back frames
    start_t.delete();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h55);
    wait_idle();
    chk("b2b_count", start_t.size(), 3);
    if (start_t.size() == 3) begin
      chk("b2b_gap1", start_t[1] - start_t[0], FRAME);
      chk("b2b_gap2", start_t[2] - start_t[1], FRAME);
    end

    // Fill, overflow, then overflow on the pop edge
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
    chk("full_after5", full, 1);
    step(1'b1, 8'h06);
    chk("ovf_6", overflow, 1);
    n = 0;
    while (rem != 1 && n < 200) begin step(1'b0, 8'h00); n++; end
    chk("wait_stop_end", n < 200, 1);
    step(1'b1, 8'h77);
    chk("ovf_77", overflow, 1);
    chk("lvl_77", level, DEPTH - 1);
    wait_idle();

    // Reset in the middle of a frame
    step(1'b1, 8'h3C);
    n = 0;
    while (rem != FRAME - 16 && n < 200) begin step(1'b0, 8'h00); n++; end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    mq.delete();
    exp_q.delete();
    rem = 0;
    frames_since_rst = 0;
    @(negedge clk);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (3) step(1'b0, 8'h00);
    chk("tx_idle_after_rst", tx, 1);
    step(1'b1, 8'h81);
    wait_idle();

    // Ten spaced writes, pointers wrap twice
    led_before = led;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'($urandom));
      repeat (FRAME + 4) step(1'b0, 8'h00);
    end
    wait_idle();
    chk("led_ten", led, led_before);

    // Random traffic, dense enough to fill and overflow
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 11) == 0, 8'($urandom));
    wait_idle();

    chk("sb_empty", exp_q.size(), 0);
    chk("done_count", done_seen, frames_total);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
